instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads 1- or 2-byte instructions from a combinational
// program memory and presents them one at a time through a valid/ready register.
module instr_fetch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_en,
  output logic [7:0]       pm_addr,
  input  logic [7:0]       pm_data,
  input  logic             redirect_valid,
  input  logic [7:0]       redirect_addr,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [7:0]       instr_op,
  output logic [7:0]       instr_imm,
  output logic             instr_len2,
  output logic [7:0]       instr_pc,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    OP   = 2'd1,
    IMM  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       imm_q, imm_d;
  logic             len2_q, len2_d;
  logic [7:0]       ipc_q, ipc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       op_hold_q, op_hold_d;
  logic [7:0]       pc_hold_q, pc_hold_d;

  logic accept;
  logic slot_free;
  logic two_byte;

  assign accept    = valid_q && instr_ready;
  assign slot_free = !valid_q || instr_ready;
  assign two_byte  = (pm_data[7:6] == 2'b10) && (pm_data[5:4] != 2'b01);

  // WAIT parks the address at 0 so the memory output settles before the first read.
  assign pm_addr = (state_q == WAIT) ? 8'h00 : pc_q;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // branches below can leave one unassigned and infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    valid_d   = valid_q && !accept;
    op_d      = op_q;
    imm_d     = imm_q;
    len2_d    = len2_q;
    ipc_d     = ipc_q;
    op_hold_d = op_hold_q;
    pc_hold_d = pc_hold_q;
    count_d   = (accept && (count_q != '1)) ? count_q + CNT_ONE : count_q;

    if (state_q != WAIT && redirect_valid) begin
      // Flush: drop the presented instruction and any half-fetched opcode.
      pc_d      = redirect_addr;
      state_d   = OP;
      valid_d   = 1'b0;
      op_hold_d = 8'h00;
    end else begin
      case (state_q)
        WAIT: state_d = OP;
        OP: begin
          if (fetch_en) begin
            if (two_byte) begin
              op_hold_d = pm_data;
              pc_hold_d = pc_q;
              pc_d      = pc_q + 8'd1;
              state_d   = IMM;
            end else if (slot_free) begin
              op_d    = pm_data;
              imm_d   = 8'h00;
              len2_d  = 1'b0;
              ipc_d   = pc_q;
              valid_d = 1'b1;
              pc_d    = pc_q + 8'd1;
            end
          end
        end
        IMM: begin
          // An immediate already under way completes regardless of fetch_en.
          if (slot_free) begin
            op_d    = op_hold_q;
            imm_d   = pm_data;
            len2_d  = 1'b1;
            ipc_d   = pc_hold_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 8'd1;
            state_d = OP;
          end
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= WAIT;
      pc_q      <= 8'h00;
      valid_q   <= 1'b0;
      op_q      <= 8'h00;
      imm_q     <= 8'h00;
      len2_q    <= 1'b0;
      ipc_q     <= 8'h00;
      count_q   <= '0;
      op_hold_q <= 8'h00;
      pc_hold_q <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      len2_q    <= len2_d;
      ipc_q     <= ipc_d;
      count_q   <= count_d;
      op_hold_q <= op_hold_d;
      pc_hold_q <= pc_hold_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr_op    = op_q;
  assign instr_imm   = imm_q;
  assign instr_len2  = len2_q;
  assign instr_pc    = ipc_q;
  assign instr_count = count_q;

endmodule
